// File: rtl/instr_prefetch_queue.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//   Instruction prefetch stage. Reads words from synchronous program memory
//   ahead of use, buffers them with their addresses in a small FIFO and hands
//   the oldest one to the IR load logic over a valid/ready handshake. A
//   redirect (taken jump/branch) flushes buffered and in-flight words and
//   restarts fetching at the new address.
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous reset, active-high
//   imem_rd_en   program memory read strobe
//   imem_addr    program memory read address (current fetch PC)
//   imem_rd_data read data, valid one cycle after an imem_rd_en cycle
//   ir_valid     head entry valid
//   ir_data      head instruction word (0 while empty)
//   ir_pc        address of the head word (0 while empty)
//   ir_ready     consumer accepts the head this cycle
//   redirect     flush and refetch from redirect_pc
//   redirect_pc  new fetch address, sampled when redirect=1
//   count        number of valid FIFO entries
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int                  DATA_W   = 16,
  parameter int                  ADDR_W   = 16,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     imem_rd_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rd_data,
  output logic                     ir_valid,
  output logic [DATA_W-1:0]        ir_data,
  output logic [ADDR_W-1:0]        ir_pc,
  input  logic                     ir_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_p0;
  logic              rd_vld_p1;
  logic [ADDR_W-1:0] rd_pc_p1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit_used;

  // Credit counts buffered entries plus the outstanding read; a pop in the
  // same cycle is deliberately not credited, which keeps ir_ready out of the
  // path to imem_rd_en.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, rd_vld_p1};
  assign issue       = !rstn && !redirect && (credit_used < DEPTH_C);
  assign imem_rd_en  = issue;
  assign imem_addr   = fetch_pc_p0;

  // A response is dropped when a redirect lands on its return cycle.
  assign push = rd_vld_p1 && !redirect;
  assign pop  = ir_valid && ir_ready;

  assign ir_valid = (count != '0);
  assign ir_data  = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? pc_mem[rd_ptr]   : '0;

  // ---- stage p0 -> p1: issue / fetch PC and FIFO control -------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      fetch_pc_p0 <= RESET_PC;
      rd_vld_p1   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc_p0 <= redirect_pc;
      rd_vld_p1   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      rd_vld_p1 <= issue;
      if (issue) begin
        fetch_pc_p0 <= fetch_pc_p0 + ADDR_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---- stage p1 -> FIFO: address of the outstanding read and storage -------
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_pc_p1 <= fetch_pc_p0;
    end
    if (push) begin
      data_mem[wr_ptr] <= imem_rd_data;
      pc_mem[wr_ptr]   <= rd_pc_p1;
    end
  end

  // The credit rule guarantees room for every returning word.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (rstn)
      !(push && (count == DEPTH_C[CNT_W-1:0]) && !pop)
  );

endmodule
